// File: rtl/set_compare_seq_pkg.sv
// Shared types and helpers for the set-on-compare unit: mode and state encodings,
// plus the flag-to-result mapping used by the result mux.
package set_compare_seq_pkg;

  typedef enum logic [2:0] {
    MODE_SLT  = 3'b000,
    MODE_SGT  = 3'b001,
    MODE_SLTU = 3'b010,
    MODE_SGTU = 3'b011,
    MODE_SEQ  = 3'b100,
    MODE_SNE  = 3'b101,
    MODE_SLE  = 3'b110,
    MODE_SGE  = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only the two unsigned modes skip the offset-binary sign flip; SLE/SGE are signed.
  function automatic logic is_signed_mode(mode_e m);
    return !((m == MODE_SLTU) || (m == MODE_SGTU));
  endfunction

  function automatic logic set_flag(mode_e m, logic gt, logic lt);
    case (m)
      MODE_SLT, MODE_SLTU: return lt;
      MODE_SGT, MODE_SGTU: return gt;
      MODE_SEQ:            return !gt && !lt;
      MODE_SNE:            return gt || lt;
      MODE_SLE:            return !gt;
      MODE_SGE:            return !lt;
      default:             return lt;
    endcase
  endfunction

endpackage

// File: rtl/set_compare_seq_if.sv
// Start/result handshake bundle for set_compare_seq; master drives operands and
// consumes results, slave is the compare unit.
interface set_compare_seq_if #(
  parameter int N = 32
);
  logic         start_valid;
  logic         start_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   mode;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] s;
  logic         busy;

  modport master (
    output start_valid, a, b, mode, res_ready,
    input  start_ready, res_valid, s, busy
  );

  modport slave (
    input  start_valid, a, b, mode, res_ready,
    output start_ready, res_valid, s, busy
  );
endinterface

// File: rtl/set_compare_seq_digit_cmp.sv
// Combinational W-bit unsigned magnitude compare; gt and lt are mutually
// exclusive and both low when the digits are equal.
module digit_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         gt,
  output logic         lt
);
  always_comb begin
    gt = (x > y);
    lt = (x < y);
  end
endmodule

// File: rtl/set_compare_seq.sv
// Multi-cycle set-on-compare: scans operands MSB-first DIGIT bits per cycle.
// Optional SET_COMPARE_EARLY_EXIT_EN finishes on the first differing digit.
module set_compare_seq #(
  parameter int N     = 32,
  parameter int DIGIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  set_compare_seq_if.slave bus
);
  import set_compare_seq_pkg::*;

  localparam int K  = (DIGIT >= 1) ? N / DIGIT : 1;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam bit BAD_CFG = (N < 2) || (DIGIT < 1) || (DIGIT > N) ||
                           (((DIGIT >= 1) ? N % DIGIT : 1) != 0);
  localparam logic [N-1:0]  SIGN_BIT = {1'b1, {(N-1){1'b0}}};
  localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

  if (BAD_CFG) begin : g_bad_cfg
    $error("set_compare_seq: N must be >= 2 and a multiple of DIGIT, 1 <= DIGIT <= N");
  end

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          gt_q, gt_d, lt_q, lt_d;
  logic          res_valid_q, res_valid_d;
  logic          flag_q, flag_d;

  logic [DIGIT-1:0] da, db;
  logic             dgt, dlt, gt_n, lt_n;
  logic             start_ready, accept, last_step;

  always_comb begin
    da = a_q[idx_q*DIGIT +: DIGIT];
    db = b_q[idx_q*DIGIT +: DIGIT];
  end

  digit_cmp #(.W(DIGIT)) u_digit_cmp (
    .x  (da),
    .y  (db),
    .gt (dgt),
    .lt (dlt)
  );

  always_comb begin
    start_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.res_ready);
    accept      = bus.start_valid && start_ready;
    // Once any digit has differed the flags are frozen: the most significant difference decides.
    gt_n        = (gt_q || lt_q) ? gt_q : dgt;
    lt_n        = (gt_q || lt_q) ? lt_q : dlt;
`ifdef SET_COMPARE_EARLY_EXIT_EN
    last_step   = (idx_q == '0) || dgt || dlt;
`else
    last_step   = (idx_q == '0);
`endif
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    gt_d        = gt_q;
    lt_d        = lt_q;
    res_valid_d = res_valid_q;
    flag_d      = flag_q;

    case (state_q)
      ST_SCAN: begin
        gt_d  = gt_n;
        lt_d  = lt_n;
        idx_d = idx_q - 1'b1;
        if (last_step) begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
          flag_d      = set_flag(mode_q, gt_n, lt_n);
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          flag_d      = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept overrides the IDLE/DONE paths above, giving back-to-back issue from DONE.
    if (accept) begin
      state_d = ST_SCAN;
      mode_d  = mode_e'(bus.mode);
      a_d     = bus.a ^ (is_signed_mode(mode_e'(bus.mode)) ? SIGN_BIT : '0);
      b_d     = bus.b ^ (is_signed_mode(mode_e'(bus.mode)) ? SIGN_BIT : '0);
      idx_d   = IDX_LAST;
      gt_d    = 1'b0;
      lt_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_SLT;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      res_valid_q <= 1'b0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      res_valid_q <= res_valid_d;
      flag_q      <= flag_d;
    end
  end

  assign bus.start_ready = start_ready;
  assign bus.res_valid   = res_valid_q;
  assign bus.s           = {{(N-1){1'b0}}, flag_q};
  assign bus.busy        = (state_q != ST_IDLE);

endmodule
